// File: rtl/fifo_rd_rr_arbiter_pkg.sv
// Shared types for the FIFO read-side round-robin arbiter.
package fifo_rd_rr_arbiter_pkg;

  // Scheduler states: IDLE arbitrates, XFER pops from the granted FIFO.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_rd_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first requesting channel found
// when scanning from rr_ptr_i upwards, wrapping from NUM_CH-1 back to 0.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   rr_ptr_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              any_o
);

  localparam logic [CH_W:0] N_EXT = (CH_W + 1)'(NUM_CH);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [2*NUM_CH-1:0] req_shift;
  logic [NUM_CH-1:0]   req_rot;
  logic [CH_W-1:0]     offset;
  logic                found;
  logic [CH_W:0]       sum;

  // Rotating a doubled copy puts the rr_ptr channel at bit 0.
  assign req_dbl   = {req_i, req_i};
  assign req_shift = req_dbl >> rr_ptr_i;
  assign req_rot   = req_shift[NUM_CH-1:0];
  assign any_o     = |req_i;

  // Lowest set bit of the rotated vector, then map back to a channel index.
  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req_rot[k]) begin
        offset = CH_W'(k);
        found  = 1'b1;
      end
    end
    sum = {1'b0, rr_ptr_i} + {1'b0, offset};
    if (sum >= N_EXT) begin
      sum = sum - N_EXT;
    end
    grant_o = sum[CH_W-1:0];
  end

endmodule

// File: rtl/fifo_rd_rr_arbiter.sv
// Read-side scheduler for NUM_CH FIFOs sharing one consumer: round-robin
// grants, bursts of up to BURST_MAX words, merged valid/ready output tagged
// with the source channel.
module fifo_rd_rr_arbiter
  import fifo_rd_rr_arbiter_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  DATA_W    = 16,
  parameter int  BURST_MAX = 8,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        fifo_empty,
  output logic [NUM_CH-1:0]        fifo_rd_en,
  input  logic [NUM_CH*DATA_W-1:0] fifo_rd_data,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [CH_W-1:0]          m_tid,
  output logic                     busy
);

  localparam int              CNT_W      = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_FULL = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    grant_q, grant_d;
  logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               m_tvalid_q;
  logic [DATA_W-1:0]  m_tdata_q;
  logic [CH_W-1:0]    m_tid_q;

  logic [NUM_CH-1:0]  req;
  logic [CH_W-1:0]    pick_grant;
  logic               pick_any;
  logic               grant_open;
  logic               pop;
  logic [DATA_W-1:0]  rd_word [NUM_CH];

  assign req = ch_en & ~fifo_empty;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick_grant),
    .any_o    (pick_any)
  );

  // A pop needs the granted FIFO readable, room in the output register and
  // burst budget left; rd_data is only trusted on the pop edge.
  assign grant_open = ch_en[grant_q] && !fifo_empty[grant_q];
  assign pop = (state_q == ST_XFER) && grant_open &&
               (!m_tvalid_q || m_tready) && (burst_cnt_q < BURST_FULL);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign rd_word[gi]    = fifo_rd_data[gi*DATA_W +: DATA_W];
      assign fifo_rd_en[gi] = pop && (grant_q == CH_W'(gi));
    end
  endgenerate

  // Next-state: arbitrate in IDLE, count pops and detect burst end in XFER.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d     = pick_grant;
          burst_cnt_d = '0;
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        if (pop) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if ((pop && burst_cnt_q == BURST_LAST) || (!pop && !grant_open)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_q == CH_LAST) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Output register: load on pop, clear on handshake, hold while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tid_q    <= '0;
    end else if (pop) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= rd_word[grant_q];
      m_tid_q    <= grant_q;
    end else if (m_tvalid_q && m_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tid    = m_tid_q;
  assign busy     = (state_q == ST_XFER);

endmodule

// File: tb/tb_fifo_rd_rr_arbiter.sv
// Bench for fifo_rd_rr_arbiter: bench-side FIFO queues, a behavioural
// scheduler model, a per-cycle compare process and directed scenarios
// followed by randomized traffic with occasional resets.
module tb_fifo_rd_rr_arbiter;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 16;
  localparam int BURST_MAX = 8;
  localparam int CH_W      = 2;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH-1:0]        fifo_rd_en;
  logic [NUM_CH*DATA_W-1:0] fifo_rd_data;
  logic                     m_tvalid;
  logic                     m_tready;
  logic [DATA_W-1:0]        m_tdata;
  logic [CH_W-1:0]          m_tid;
  logic                     busy;

  fifo_rd_rr_arbiter #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ch_en        (ch_en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tid        (m_tid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Behavioural model: is a burst open, on which channel, how many words it
  // has taken, where the next search starts, and the word held for output.
  bit              mbusy;
  logic [CH_W-1:0] mch;
  logic [3:0]      mcnt;
  logic [CH_W-1:0] mnext;
  bit              mv;
  logic [15:0]     md;
  logic [CH_W-1:0] mt;

  logic [DATA_W-1:0] fq [NUM_CH][$];
  int pushed  = 0;
  int dropped = 0;

  // Written only by the compare process.
  int              del_cnt = 0;
  logic [CH_W-1:0] del_tid [$];
  int              del_cyc [$];
  logic [15:0]     del_data[$];
  int              rd_cnt  [NUM_CH];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // A FIFO is read exactly when a burst is open on it, it has data and is
  // enabled, the output slot is free or draining, and the budget is not spent.
  function automatic logic [NUM_CH-1:0] exp_rd_en();
    logic [NUM_CH-1:0] r;
    r = '0;
    if (mbusy && ch_en[mch] && fq[mch].size() > 0 && (!mv || m_tready) && mcnt < 4'(BURST_MAX))
      r[mch] = 1'b1;
    return r;
  endfunction

  function automatic bit all_idle();
    bit e;
    e = !mv && !mbusy;
    for (int c = 0; c < NUM_CH; c++) if (fq[c].size() != 0) e = 0;
    return e;
  endfunction

  task automatic model_reset();
    if (mv) dropped++;
    mbusy = 0; mch = '0; mcnt = '0; mnext = '0; mv = 0; md = '0; mt = '0;
  endtask

  // One rising edge of the scheduler, in terms of bursts and held words.
  task automatic model_step();
    bit p;
    bit found;
    logic [CH_W-1:0] c;
    if (!resetn) return;
    p = |exp_rd_en();
    if (p) begin
      md = fq[mch].pop_front();
      mv = 1; mt = mch; mcnt = mcnt + 4'd1;
    end else if (mv && m_tready) begin
      mv = 0;
    end
    if (!mbusy) begin
      found = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        c = mnext + 2'(k);
        if (!found && ch_en[c] && fq[c].size() > 0) begin
          found = 1; mbusy = 1; mch = c; mcnt = '0;
        end
      end
    end else if ((p && mcnt == 4'(BURST_MAX)) || (!p && (!ch_en[mch] || fq[mch].size() == 0))) begin
      mbusy = 0;
      mnext = mch + 2'd1;
    end
  endtask

  task automatic drive_fifos();
    for (int c = 0; c < NUM_CH; c++) begin
      fifo_empty[c] = (fq[c].size() == 0);
      fifo_rd_data[c*DATA_W +: DATA_W] = (fq[c].size() != 0) ? fq[c][0] : 16'($urandom);
    end
  endtask

  task automatic push_val(input int c, input logic [15:0] v);
    fq[c].push_back(v);
    pushed++;
    drive_fifos();
  endtask

  task automatic push_rand(input int c, input int n);
    for (int i = 0; i < n; i++) push_val(c, 16'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    drive_fifos();
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    model_reset();
    repeat (n) tick();
    chk(fifo_rd_en == '0 && m_tvalid == 1'b0, "reset_hold_quiet", 64'({fifo_rd_en, m_tvalid}), 64'h0);
    resetn = 1'b1;
  endtask

  task automatic wait_del(input int target, input int budget, input string name);
    int b;
    b = 0;
    while (del_cnt < target && b < budget) begin tick(); b++; end
    chk(del_cnt >= target, name, 64'(del_cnt), 64'(target));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int b;
    b = 0;
    while (!all_idle() && b < budget) begin tick(); b++; end
    tick();
    chk(busy == 1'b0 && m_tvalid == 1'b0 && all_idle(), name, 64'({busy, m_tvalid}), 64'h0);
  endtask

  // Per-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    chk(m_tvalid == mv, "m_tvalid", 64'(m_tvalid), 64'(mv));
    if (mv) begin
      chk(m_tdata == md, "m_tdata", 64'(m_tdata), 64'(md));
      chk(m_tid == mt, "m_tid", 64'(m_tid), 64'(mt));
    end
    chk(busy == mbusy, "busy", 64'(busy), 64'(mbusy));
    chk(fifo_rd_en == exp_rd_en(), "fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd_en()));
    if (!resetn)
      chk(m_tdata == 16'h0 && m_tid == 2'd0, "reset_outputs", 64'({m_tdata, m_tid}), 64'h0);
    for (int c = 0; c < NUM_CH; c++) if (fifo_rd_en[c]) rd_cnt[c]++;
    if (m_tvalid && m_tready) begin
      del_cnt++;
      del_tid.push_back(m_tid);
      del_cyc.push_back(cyc);
      del_data.push_back(m_tdata);
      $display("xfer cyc=%0d ch=%0d data=%04h", cyc, m_tid, m_tdata);
    end
  end

  initial begin
    int s, bad;
    int r1, r2;
    logic [7:0] tids;

    for (int c = 0; c < NUM_CH; c++) rd_cnt[c] = 0;
    resetn   = 1'b0;
    ch_en    = 4'hF;
    m_tready = 1'b1;
    fifo_empty   = '1;
    fifo_rd_data = '0;
    model_reset();

    // Reset with every FIFO non-empty: nothing is read, nothing is offered.
    for (int c = 0; c < NUM_CH; c++) push_rand(c, 20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(fifo_rd_en == '0 && m_tvalid == 1'b0 && m_tid == 2'd0, "reset_quiet",
          64'({fifo_rd_en, m_tvalid, m_tid}), 64'h0);
    end
    resetn = 1'b1;

    // Fairness: four full channels, bursts of eight in channel order.
    s = del_tid.size();
    wait_del(s + 64, 300, "fairness_timeout");
    bad = 0;
    for (int i = 0; i < 64; i++) if (del_tid[s+i] != 2'((i / 8) % 4)) bad++;
    chk(bad == 0, "fairness_seq", 64'(bad), 64'h0);
    wait_idle(200, "drain_after_fairness");

    // Early end: lone channel with three words, delivered back to back.
    s = del_tid.size();
    push_rand(1, 3);
    wait_del(s + 3, 50, "early_end_timeout");
    chk(del_tid[s] == 2'd1 && del_tid[s+1] == 2'd1 && del_tid[s+2] == 2'd1, "early_end_tid",
        64'({del_tid[s], del_tid[s+1], del_tid[s+2]}), 64'h15);
    chk(del_cyc[s+1] - del_cyc[s] == 1 && del_cyc[s+2] - del_cyc[s+1] == 1, "early_end_rate",
        64'(del_cyc[s+2] - del_cyc[s]), 64'h2);
    tick(); tick();
    chk(busy == 1'b0, "early_end_idle", 64'(busy), 64'h0);

    // Backpressure: stall five clocks with the fourth word held.
    s = del_tid.size();
    for (int i = 0; i < 8; i++) push_val(2, 16'hD000 + 16'(i));
    wait_del(s + 3, 50, "stall_lead_timeout");
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(m_tvalid == 1'b1 && m_tdata == 16'hD003 && m_tid == 2'd2 && fifo_rd_en == '0, "stall_hold",
          64'({m_tvalid, m_tdata, m_tid, fifo_rd_en}), 64'({1'b1, 16'hD003, 2'd2, 4'h0}));
    end
    m_tready = 1'b1;
    wait_del(s + 8, 50, "stall_drain_timeout");
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (del_data[s+i] != 16'hD000 + 16'(i) || del_tid[s+i] != 2'd2) bad++;
    chk(bad == 0, "stall_no_loss", 64'(bad), 64'h0);
    wait_idle(50, "drain_after_stall");

    // Wrap and mask: search starts at ch3, only ch3 and ch0 enabled.
    s = del_tid.size();
    r1 = rd_cnt[1];
    r2 = rd_cnt[2];
    ch_en = 4'b1001;
    for (int c = 0; c < NUM_CH; c++) push_rand(c, 2);
    wait_del(s + 4, 50, "wrap_timeout");
    repeat (5) tick();
    tids = {del_tid[s], del_tid[s+1], del_tid[s+2], del_tid[s+3]};
    chk(tids == 8'hF0, "wrap_mask_order", 64'(tids), 64'hF0);
    chk(rd_cnt[1] == r1 && rd_cnt[2] == r2, "masked_never_read", 64'(rd_cnt[1] - r1 + rd_cnt[2] - r2), 64'h0);

    // Reset mid-burst: after release the search restarts at ch0.
    ch_en = 4'hF;
    for (int c = 0; c < NUM_CH; c++) push_rand(c, 10);
    s = del_tid.size();
    wait_del(s + 3, 50, "mid_burst_lead_timeout");
    do_reset(2);
    s = del_tid.size();
    wait_del(s + 1, 50, "post_reset_timeout");
    chk(del_tid[s] == 2'd0, "post_reset_ch0", 64'(del_tid[s]), 64'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_en[c] = ($urandom_range(7) != 0);
        if ($urandom_range(2) == 0 && fq[c].size() < 12) push_rand(c, 1);
      end
      m_tready = ($urandom_range(3) != 0);
      if ($urandom_range(299) == 0) do_reset(1 + $urandom_range(1));
      else tick();
    end

    // Drain and account for every word pushed.
    ch_en = 4'hF;
    m_tready = 1'b1;
    wait_idle(2000, "final_drain");
    chk(del_cnt == pushed - dropped, "word_accounting", 64'(del_cnt), 64'(pushed - dropped));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
